hbridge_reversal_guard: RTL and testbench

//  Sits between the PWM/direction stage and the H-bridge pins (IN1/IN2, EN).

---
 rtl/hbridge_reversal_guard_pkg.sv | 31 +++
 rtl/hbridge_interval_timer.sv | 35 +++
 rtl/hbridge_reversal_guard.sv | 155 +++++++++++++++
 tb/tb_hbridge_reversal_guard.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hbridge_reversal_guard_pkg.sv
// ============================================================================
// hbridge_reversal_guard_pkg : state/direction encodings and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package hbridge_reversal_guard_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_COAST = 2'd1,
      ST_BRAKE = 2'd2
   } state_e;

   localparam logic [1:0] DIR_COAST = 2'b00;
   localparam logic [1:0] DIR_REV   = 2'b01;
   localparam logic [1:0] DIR_FWD   = 2'b10;
   localparam logic [1:0] DIR_BRAKE = 2'b11;

   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return ((a == DIR_REV) && (b == DIR_FWD)) || ((a == DIR_FWD) && (b == DIR_REV));
   endfunction

   // Codes that never drive current through the motor in a new direction
   function automatic logic is_passive(input logic [1:0] d);
      return (d == DIR_COAST) || (d == DIR_BRAKE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hbridge_interval_timer.sv
// ============================================================================
// hbridge_interval_timer : loadable down-counter that parks at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module hbridge_interval_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] value_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign value_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/hbridge_reversal_guard.sv
// ============================================================================
// hbridge_reversal_guard : blocks direct H-bridge reversals by inserting
// coast dead-time and a timed brake; counts completed reversals.
// Rev 1.0
// ============================================================================
`default_nettype none

module hbridge_reversal_guard
   import hbridge_reversal_guard_pkg::*;
#(
   parameter int DEAD_CYC  = 5_000_000,
   parameter int BRAKE_CYC = 20_000_000,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   input  logic [1:0]       dir_req,
   output logic             pwm_out,
   output logic [1:0]       in1_in2_out,
   output logic             busy,
   output logic [CNT_W-1:0] rev_count
);

   localparam int MAX_CYC = (DEAD_CYC > BRAKE_CYC) ? DEAD_CYC : BRAKE_CYC;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0] DEAD_VAL  = TW'(DEAD_CYC - 1);
   localparam logic [TW-1:0] BRAKE_VAL = TW'(BRAKE_CYC - 1);

   state_e           state_q,   state_d;
   logic [1:0]       applied_q, applied_d;
   logic [1:0]       target_q,  target_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             pwm_q,     pwm_d;
   logic [1:0]       dir_out_q, dir_out_d;
   logic             busy_q,    busy_d;

   logic             w_tmr_load;
   logic [TW-1:0]    w_tmr_val;
   logic             w_tmr_zero;
   // Remaining count is a debug tap; only expiry steers the FSM
   logic [TW-1:0]    w_tmr_value_unused;

   hbridge_interval_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (w_tmr_load),
      .load_val_i (w_tmr_val),
      .value_o    (w_tmr_value_unused),
      .zero_o     (w_tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         applied_q <= DIR_COAST;
         target_q  <= DIR_COAST;
         cnt_q     <= '0;
         pwm_q     <= 1'b0;
         dir_out_q <= DIR_COAST;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         applied_q <= applied_d;
         target_q  <= target_d;
         cnt_q     <= cnt_d;
         pwm_q     <= pwm_d;
         dir_out_q <= dir_out_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      applied_d  = applied_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      w_tmr_load = 1'b0;
      w_tmr_val  = DEAD_VAL;
      case (state_q)
         ST_RUN: begin
            if (dir_req != applied_q) begin
               if (is_opposite(applied_q, dir_req)) begin
                  state_d    = ST_COAST;
                  target_d   = dir_req;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = DEAD_VAL;
               end else begin
                  applied_d = dir_req;
               end
            end
         end
         ST_COAST: begin
            target_d = dir_req;
            if (dir_req == applied_q) begin
               state_d = ST_RUN;
            end else if (is_passive(dir_req)) begin
               applied_d = dir_req;
               state_d   = ST_RUN;
            end else if (w_tmr_zero) begin
               state_d    = ST_BRAKE;
               w_tmr_load = 1'b1;
               w_tmr_val  = BRAKE_VAL;
            end
         end
         ST_BRAKE: begin
            // applied_q still holds the pre-reversal code until brake ends
            target_d = dir_req;
            if (w_tmr_zero) begin
               state_d   = ST_RUN;
               applied_d = target_q;
               if (is_opposite(applied_q, target_q) && (cnt_q != '1)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_comb begin
      pwm_d     = 1'b0;
      dir_out_d = applied_d;
      busy_d    = 1'b0;
      case (state_d)
         ST_RUN: begin
            pwm_d = pwm_in;
         end
         ST_COAST: begin
            dir_out_d = applied_q;
            busy_d    = 1'b1;
         end
         ST_BRAKE: begin
            pwm_d     = 1'b1;
            dir_out_d = DIR_BRAKE;
            busy_d    = 1'b1;
         end
         default: begin
            pwm_d = 1'b0;
         end
      endcase
   end

   assign pwm_out     = pwm_q;
   assign in1_in2_out = dir_out_q;
   assign busy        = busy_q;
   assign rev_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hbridge_reversal_guard.sv
// ============================================================================
// tb_hbridge_reversal_guard : directed vectors with a queued scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hbridge_reversal_guard;
   import hbridge_reversal_guard_pkg::*;

   localparam int DEAD_CYC  = 4;
   localparam int BRAKE_CYC = 6;
   localparam int CNT_W     = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pwm_in = 1'b0;
   logic [1:0]       dir_req = 2'b00;
   logic             pwm_out;
   logic [1:0]       in1_in2_out;
   logic             busy;
   logic [CNT_W-1:0] rev_count;

   typedef struct {
      logic             pwm;
      logic [1:0]       dir;
      logic             busy;
      logic [CNT_W-1:0] cnt;
      string            tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   hbridge_reversal_guard #(
      .DEAD_CYC  (DEAD_CYC),
      .BRAKE_CYC (BRAKE_CYC),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .dir_req     (dir_req),
      .pwm_out     (pwm_out),
      .in1_in2_out (in1_in2_out),
      .busy        (busy),
      .rev_count   (rev_count)
   );

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic step(input logic r, input logic p, input logic [1:0] d,
                       input logic ep, input logic [1:0] ed, input logic eb,
                       input logic [CNT_W-1:0] ec, input string tag);
      exp_t e;
      @(negedge clk);
      rst     = r;
      pwm_in  = p;
      dir_req = d;
      e.pwm  = ep;
      e.dir  = ed;
      e.busy = eb;
      e.cnt  = ec;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   // Full reversal from_d -> to_d; brake_req is what dir_req shows after brake cycle 1
   task automatic reversal(input logic [1:0] from_d, input logic [1:0] to_d,
                           input logic [1:0] brake_req,
                           input logic [CNT_W-1:0] cb, input logic [CNT_W-1:0] ca);
      for (int i = 0; i < DEAD_CYC; i++)
         step(1'b0, 1'b1, to_d, 1'b0, from_d, 1'b1, cb, "coast");
      for (int i = 0; i < BRAKE_CYC; i++)
         step(1'b0, 1'b0, (i == 0) ? to_d : brake_req, 1'b1, DIR_BRAKE, 1'b1, cb, "brake");
      step(1'b0, 1'b1, brake_req, 1'b1, brake_req, 1'b0, ca, "resume");
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if (pwm_out === mon_e.pwm && in1_in2_out === mon_e.dir &&
             busy === mon_e.busy && rev_count === mon_e.cnt) begin
            n_pass++;
         end else begin
            $display("FAIL %s @%0t: pwm/dir/busy/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     mon_e.tag, $time, pwm_out, in1_in2_out, busy, rev_count,
                     mon_e.pwm, mon_e.dir, mon_e.busy, mon_e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset held while inputs wiggle
      step(1'b1, 1'b1, DIR_FWD,   1'b0, DIR_COAST, 1'b0, 2'd0, "rst_hold0");
      step(1'b1, 1'b0, DIR_REV,   1'b0, DIR_COAST, 1'b0, 2'd0, "rst_hold1");
      step(1'b1, 1'b1, DIR_BRAKE, 1'b0, DIR_COAST, 1'b0, 2'd0, "rst_hold2");
      step(1'b0, 1'b0, DIR_FWD,   1'b0, DIR_FWD,   1'b0, 2'd0, "release_fwd");

      // PWM follows with one cycle latency, then a full reversal
      step(1'b0, 1'b1, DIR_FWD, 1'b1, DIR_FWD, 1'b0, 2'd0, "pwm_follow1");
      step(1'b0, 1'b0, DIR_FWD, 1'b0, DIR_FWD, 1'b0, 2'd0, "pwm_follow0");
      step(1'b0, 1'b1, DIR_FWD, 1'b1, DIR_FWD, 1'b0, 2'd0, "pwm_follow1b");
      reversal(DIR_FWD, DIR_REV, DIR_REV, 2'd0, 2'd1);

      // Back to FWD via coast, then reversal aborted during coast
      step(1'b0, 1'b1, DIR_COAST, 1'b1, DIR_COAST, 1'b0, 2'd1, "to_coast");
      step(1'b0, 1'b0, DIR_FWD,   1'b0, DIR_FWD,   1'b0, 2'd1, "to_fwd");
      step(1'b0, 1'b1, DIR_REV,   1'b0, DIR_FWD,   1'b1, 2'd1, "abort_c1");
      step(1'b0, 1'b1, DIR_REV,   1'b0, DIR_FWD,   1'b1, 2'd1, "abort_c2");
      step(1'b0, 1'b1, DIR_FWD,   1'b1, DIR_FWD,   1'b0, 2'd1, "abort_run");

      // Request changes during brake: brake completes, no count
      reversal(DIR_FWD, DIR_REV, DIR_FWD,   2'd1, 2'd1);
      reversal(DIR_FWD, DIR_REV, DIR_COAST, 2'd1, 2'd1);

      // Direct changes through passive codes
      step(1'b0, 1'b0, DIR_FWD,   1'b0, DIR_FWD,   1'b0, 2'd1, "d_00_10");
      step(1'b0, 1'b1, DIR_COAST, 1'b1, DIR_COAST, 1'b0, 2'd1, "d_10_00");
      step(1'b0, 1'b1, DIR_REV,   1'b1, DIR_REV,   1'b0, 2'd1, "d_00_01");
      step(1'b0, 1'b0, DIR_BRAKE, 1'b0, DIR_BRAKE, 1'b0, 2'd1, "d_01_11");
      step(1'b0, 1'b1, DIR_FWD,   1'b1, DIR_FWD,   1'b0, 2'd1, "d_11_10");

      // Counter saturation from a clean reset
      step(1'b1, 1'b1, DIR_FWD, 1'b0, DIR_COAST, 1'b0, 2'd0, "rst_again");
      step(1'b0, 1'b0, DIR_FWD, 1'b0, DIR_FWD,   1'b0, 2'd0, "fwd_again");
      reversal(DIR_FWD, DIR_REV, DIR_REV, 2'd0, 2'd1);
      reversal(DIR_REV, DIR_FWD, DIR_FWD, 2'd1, 2'd2);
      reversal(DIR_FWD, DIR_REV, DIR_REV, 2'd2, 2'd3);
      reversal(DIR_REV, DIR_FWD, DIR_FWD, 2'd3, 2'd3);
      reversal(DIR_FWD, DIR_REV, DIR_REV, 2'd3, 2'd3);

      // Reset in the middle of a brake
      for (int i = 0; i < DEAD_CYC; i++)
         step(1'b0, 1'b1, DIR_FWD, 1'b0, DIR_REV, 1'b1, 2'd3, "coast_pre_rst");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, DIR_FWD, 1'b1, DIR_BRAKE, 1'b1, 2'd3, "brake_pre_rst");
      step(1'b1, 1'b0, DIR_FWD,   1'b0, DIR_COAST, 1'b0, 2'd0, "rst_mid_brake");
      step(1'b0, 1'b1, DIR_COAST, 1'b1, DIR_COAST, 1'b0, 2'd0, "post_rst_run");
      step(1'b0, 1'b0, DIR_FWD,   1'b0, DIR_FWD,   1'b0, 2'd0, "post_rst_fwd");

      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: pending expectations got %0d required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
